// File: rtl/btn_event_if.sv
// Button event bus: debounced level in, registered event pulses and debug state out.
// The release pulse is named release_o because "release" is a reserved word.
interface btn_event_if;
    logic       btn_ok_i;
    logic       press_o;
    logic       release_o;
    logic       click_o;
    logic       double_click_o;
    logic       long_press_o;
    logic [2:0] state_o;

    modport slave (
        input  btn_ok_i,
        output press_o,
        output release_o,
        output click_o,
        output double_click_o,
        output long_press_o,
        output state_o
    );

    modport master (
        output btn_ok_i,
        input  press_o,
        input  release_o,
        input  click_o,
        input  double_click_o,
        input  long_press_o,
        input  state_o
    );
endinterface

// File: rtl/btn_event.sv
// Classifies a debounced button level into press/release/click/double-click/long-press pulses.
//
// state          | meaning
// IDLE           | button up, nothing pending
// PRESSED        | first press in progress, counting hold time
// LONG_HELD      | long press already reported, waiting for release
// WAIT_SECOND    | short press released, timing the double-click window
// SECOND_PRESSED | second press of a double click in progress
module btn_event #(
    parameter int CNT_W         = 27,
    parameter int LONG_CYCLES   = 100_000_000,
    parameter int DCLICK_CYCLES = 30_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    btn_event_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE           = 3'd0,
        PRESSED        = 3'd1,
        LONG_HELD      = 3'd2,
        WAIT_SECOND    = 3'd3,
        SECOND_PRESSED = 3'd4
    } state_e;

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               btn_q;
    logic               rise, fall;
    logic               press_q, press_d;
    logic               release_q, release_d;
    logic               click_q, click_d;
    logic               dclick_q, dclick_d;
    logic               long_q, long_d;

    assign rise = bus.btn_ok_i & ~btn_q;
    assign fall = ~bus.btn_ok_i & btn_q;

    // Saturating increment: the counter holds at all-ones instead of wrapping.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        dclick_d  = 1'b0;
        long_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = PRESSED;
                end
            end

            PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = WAIT_SECOND;
                end else if (bus.btn_ok_i && cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = LONG_HELD;
                end else if (bus.btn_ok_i) begin
                    cnt_d = cnt_inc;
                end
            end

            LONG_HELD: begin
                if (fall) begin
                    release_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end
            end

            // A rise on the timeout cycle still counts as the second press.
            WAIT_SECOND: begin
                if (rise) begin
                    press_d = 1'b1;
                    cnt_d   = '0;
                    state_d = SECOND_PRESSED;
                end else if (cnt_q == DCLICK_LAST) begin
                    click_d = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            SECOND_PRESSED: begin
                if (fall) begin
                    release_d = 1'b1;
                    dclick_d  = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else if (bus.btn_ok_i && cnt_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = LONG_HELD;
                end else if (bus.btn_ok_i) begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            btn_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            dclick_q  <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            btn_q     <= bus.btn_ok_i;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            dclick_q  <= dclick_d;
            long_q    <= long_d;
        end
    end

    assign bus.press_o        = press_q;
    assign bus.release_o      = release_q;
    assign bus.click_o        = click_q;
    assign bus.double_click_o = dclick_q;
    assign bus.long_press_o   = long_q;
    assign bus.state_o        = state_q;

endmodule

// File: doc/btn_event.md
BTN_EVENT -- requirements
Module: btn_event

Interface
REQ-001 Parameter CNT_W, default 27: width of the internal cycle counter.
REQ-002 Parameter LONG_CYCLES, default 100_000_000: continuous-press cycles that qualify as a long press (1 s at 100 MHz).
REQ-003 Parameter DCLICK_CYCLES, default 30_000_000: maximum release-to-second-press gap for a double click (0.3 s).
REQ-004 Port clk  input  1  sole clock; all logic on posedge clk.
REQ-005 Port rst_n  input  1  reset: synchronous, active-low.
REQ-006 Port BTN_OK  input  1  debounced button level from the upstream anti-jitter stage, synchronous to clk.
REQ-007 Port press  output  1  one-cycle pulse on each press (rising edge of BTN_OK).
REQ-008 Port release  output  1  one-cycle pulse on each release (falling edge of BTN_OK).
REQ-009 Port click  output  1  one-cycle pulse for a completed single short click.
REQ-010 Port double_click  output  1  one-cycle pulse for a completed double click.
REQ-011 Port long_press  output  1  one-cycle pulse when a press reaches LONG_CYCLES.
REQ-012 Port state  output  3  current FSM state code, for debug.

Function
REQ-013 The block SHALL register BTN_OK into btn_q; rise = BTN_OK & ~btn_q, fall = ~BTN_OK & btn_q.
REQ-014 All outputs SHALL be registered; each pulse is high for exactly one cycle, starting at the edge where the triggering condition is sampled (latency 1 edge from BTN_OK change).
REQ-015 FSM states and codes SHALL be IDLE=0, PRESSED=1, LONG_HELD=2, WAIT_SECOND=3, SECOND_PRESSED=4; codes 5-7 SHALL return to IDLE on the next edge.
REQ-016 IDLE: on rise -> press, cnt=0, go PRESSED; otherwise stay.
REQ-017 PRESSED: BTN_OK high -> cnt+1; when cnt reaches LONG_CYCLES-1 -> long_press, go LONG_HELD; on fall -> release, cnt=0, go WAIT_SECOND.
REQ-018 LONG_HELD: on fall -> release, go IDLE; no click or double_click SHALL be emitted for a long press.
REQ-019 WAIT_SECOND: cnt+1 each cycle; on rise -> press, cnt=0, go SECOND_PRESSED; when cnt reaches DCLICK_CYCLES-1 without rise -> click, go IDLE.
REQ-020 Simultaneous rise and timeout in WAIT_SECOND: rise SHALL win (press, SECOND_PRESSED, no click).
REQ-021 SECOND_PRESSED: on fall -> release and double_click in the same cycle, go IDLE; when cnt reaches LONG_CYCLES-1 -> long_press, go LONG_HELD, no double_click.
REQ-022 cnt SHALL saturate, never wrap; it resets to 0 on every state change.
REQ-023 At most one of click, double_click, long_press SHALL be high in any cycle; press and release SHALL never be high together.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force state=IDLE, cnt=0, btn_q=0, and all pulse outputs=0, overriding any event in that cycle.
REQ-025 If BTN_OK is high when rst_n is released, btn_q=0 SHALL yield press on the first edge after reset; reset mid-sequence SHALL discard pending click/double_click.

Verification (LONG_CYCLES=8, DCLICK_CYCLES=4)
REQ-026 BTN_OK high 3 cycles, then low 6 -> press at edge 1, release at edge 4, click 4 edges after release, state returns to 0.
REQ-027 BTN_OK high 3, low 2, high 3, low -> press, release, press, then release and double_click together; no click.
REQ-028 BTN_OK high 12 cycles -> press, long_press 8 edges after press, state=2, release on fall, no click.
REQ-029 Release, then rise on the exact cycle cnt=3 in WAIT_SECOND -> press and state=4, no click.
REQ-030 rst_n low for 1 cycle while in WAIT_SECOND -> all outputs 0, state=0, no click afterwards.
REQ-031 BTN_OK held high across rst_n deassertion -> press one edge after reset release, then long_press after 8 edges.
